// File: rtl/ifu_pcgen.sv
// Small circular FIFO with flush; head is read combinationally from storage.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: none internally; the caller must never push when full or pop when empty.
module ifu_pcgen_fifo #(
    parameter int  W     = 32,
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_push,
    input  logic [W-1:0]  i_push_dat,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [W-1:0]  o_head_dat,
    output logic [CW-1:0] o_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    // Storage, pointers and occupancy; a flush empties the queue and also drops a same-cycle push.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (i_flush) begin
                r_rd_ptr <= r_wr_ptr + AW'(i_push);
                r_count  <= '0;
            end else begin
                if (i_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
                r_count <= r_count + CW'(i_push) - CW'(i_pop);
            end
        end
    end
endmodule

// Fetch PC generator: issues word-aligned fetches on an in-order imem port, buffers responses for decode.
// Latency: redirect -> new fetch address next cycle; imem response -> if_valid the following cycle.
// Backpressure: in-flight + buffered never exceeds MAX_OUT; a stalled if_ready eventually stops fetching.
module ifu_pcgen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              MAX_OUT   = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_inst,
    input  logic            if_ready
);
    localparam int              CW         = $clog2(MAX_OUT + 1);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef enum logic {BOOT, FETCH} state_e;

    state_e          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pend_pc;
    logic            r_pend_vld;
    logic            r_hold;     // request was offered last cycle and not granted
    logic [CW-1:0]   r_kill;     // responses still to arrive that belong to a squashed path

    logic [CW-1:0]        w_out;       // granted but not yet returned (depth of the PC queue)
    logic [CW-1:0]        w_cnt;       // instructions buffered for decode
    logic [XLEN-1:0]      w_rsp_pc;
    logic [XLEN+31:0]     w_head;
    logic                 w_gnt;
    logic                 w_wait;
    logic                 w_rsp;
    logic                 w_drop;
    logic                 w_push;
    logic                 w_pop;
    logic [CW:0]          w_load;
    logic                 w_room;
    logic [XLEN-1:0]      w_redir_pc;

    assign w_gnt      = imem_req & imem_gnt;
    assign w_wait     = imem_req & ~imem_gnt;
    assign w_rsp      = imem_rvalid & (w_out != '0);   // stray rvalid with nothing in flight is ignored
    assign w_drop     = (r_kill != '0);
    assign w_push     = w_rsp & ~w_drop & ~redirect_valid;
    assign w_pop      = if_valid & if_ready;
    assign w_redir_pc = redirect_pc & ALIGN_MASK;

    // A head being consumed this cycle frees its slot, which keeps single-cycle memories at full rate.
    assign w_load   = {1'b0, w_out} + {1'b0, w_cnt} - {{CW{1'b0}}, w_pop};
    assign w_room   = (w_load < (CW + 1)'(MAX_OUT));
    assign imem_req = (r_state == FETCH) && (r_hold || (w_room && !r_pend_vld));
    assign imem_addr = r_pc;

    assign if_valid = (w_cnt != '0);
    assign if_pc    = w_head[XLEN+31:32];
    assign if_inst  = w_head[31:0];

    ifu_pcgen_fifo #(.W(XLEN), .DEPTH(MAX_OUT)) u_pc_q (
        .clk        (clk),
        .rstn       (rstn),
        .i_push     (w_gnt),
        .i_push_dat (imem_addr),
        .i_pop      (w_rsp),
        .i_flush    (1'b0),
        .o_head_dat (w_rsp_pc),
        .o_count    (w_out)
    );

    ifu_pcgen_fifo #(.W(XLEN + 32), .DEPTH(MAX_OUT)) u_inst_q (
        .clk        (clk),
        .rstn       (rstn),
        .i_push     (w_push),
        .i_push_dat ({w_rsp_pc, imem_rdata}),
        .i_pop      (w_pop),
        .i_flush    (redirect_valid),
        .o_head_dat (w_head),
        .o_count    (w_cnt)
    );

    // Boot/fetch sequencing, next-PC selection, held-request tracking and squash accounting.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= BOOT;
            r_pc       <= RESET_VEC & ALIGN_MASK;
            r_pend_pc  <= '0;
            r_pend_vld <= 1'b0;
            r_hold     <= 1'b0;
            r_kill     <= '0;
        end else begin
            r_state <= FETCH;
            r_hold  <= w_wait;

            if (redirect_valid) begin
                if (w_wait) begin
                    // The offered address must stay on the bus; park the target until the grant.
                    r_pend_pc  <= w_redir_pc;
                    r_pend_vld <= 1'b1;
                end else begin
                    r_pc       <= w_redir_pc;
                    r_pend_vld <= 1'b0;
                end
            end else if (w_gnt) begin
                if (r_pend_vld) begin
                    r_pc       <= r_pend_pc;
                    r_pend_vld <= 1'b0;
                end else begin
                    r_pc <= r_pc + XLEN'(4);
                end
            end

            // Everything in flight after this edge is wrong-path once a redirect is seen;
            // the grant of a parked request is wrong-path as well.
            if (redirect_valid) begin
                r_kill <= w_out - CW'(w_rsp) + CW'(w_gnt);
            end else begin
                r_kill <= r_kill - CW'(w_rsp & w_drop) + CW'(w_gnt & r_pend_vld);
            end
        end
    end
endmodule

// File: tb/tb_ifu_pcgen.sv
// Randomized bench for ifu_pcgen against a fetch-stream reference model.
// Latency: model is evaluated once per cycle, between the falling edge and the next rising edge.
// Backpressure: imem grant/response and if_ready are randomized per phase.
module tb_ifu_pcgen;
    localparam int          MAX_OUT   = 2;
    localparam logic [31:0] RESET_VEC = 32'h0000_0000;

    logic        clk;
    logic        rstn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;

    ifu_pcgen #(.XLEN(32), .RESET_VEC(RESET_VEC), .MAX_OUT(MAX_OUT)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_ready       (if_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_gnt = 0;
    int n_dlv = 0;
    int gnt_pct, rv_pct, rdy_pct, redir_pct;
    bit spur_en, frc_vld, stale, prev_wait, arm_first;
    logic [31:0] frc_pc, stale_addr, prev_addr, exp_fetch, exp_dlv, first_dlv;
    logic [31:0] mem_q[$];   // granted addresses awaiting a response, in bus order

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
    endfunction

    function automatic bit pct(input int p);
        return ($urandom_range(99) < p);
    endfunction

    function automatic logic [31:0] rand_target();
        if ($urandom_range(7) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(15));
        return $urandom & 32'h0000_3FFF;
    endfunction

    task automatic set_knobs(input int g, input int r, input int d, input int x);
        gnt_pct = g; rv_pct = r; rdy_pct = d; redir_pct = x;
    endtask

    task automatic frc(input logic [31:0] pc);
        frc_vld = 1'b1; frc_pc = pc;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        redirect_valid = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; if_ready = 1'b0;
        #1;
        chk("rst_req",  {31'd0, imem_req}, 32'd0);
        chk("rst_vld",  {31'd0, if_valid}, 32'd0);
        chk("rst_addr", imem_addr, RESET_VEC);
        chk("rst_pc",   if_pc, 32'd0);
        chk("rst_inst", if_inst, 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        mem_q.delete();
        stale = 0; prev_wait = 0; arm_first = 0; frc_vld = 0;
        exp_fetch = RESET_VEC; exp_dlv = RESET_VEC;
    endtask

    // One bus cycle: drive, sample, then advance the reference model by the events of the coming edge.
    task automatic step();
        @(negedge clk);
        imem_gnt = pct(gnt_pct);
        if (mem_q.size() > 0) begin
            imem_rvalid = pct(rv_pct);
            imem_rdata  = mem_of(mem_q[0]);
        end else begin
            imem_rvalid = spur_en && pct(20);
            imem_rdata  = $urandom;
        end
        if_ready = pct(rdy_pct);
        if (frc_vld) begin
            redirect_valid = 1'b1; redirect_pc = frc_pc; frc_vld = 0;
        end else begin
            redirect_valid = pct(redir_pct); redirect_pc = rand_target();
        end
        #1;
        if (prev_wait) begin
            chk("hold_req",  {31'd0, imem_req}, 32'd1);
            chk("hold_addr", imem_addr, prev_addr);
        end
        chk("inflight_bound", {31'd0, (mem_q.size() <= MAX_OUT)}, 32'd1);
        if (if_valid && if_ready) begin
            chk("if_pc",   if_pc,   exp_dlv);
            chk("if_inst", if_inst, mem_of(exp_dlv));
            if (arm_first) begin first_dlv = if_pc; arm_first = 0; end
            exp_dlv = exp_dlv + 32'd4;
            n_dlv++;
        end
        if (imem_rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
        if (imem_req && imem_gnt) begin
            if (stale) begin
                chk("stale_addr", imem_addr, stale_addr);
                stale = 0;
            end else begin
                chk("fetch_addr", imem_addr, exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
            end
            mem_q.push_back(imem_addr);
            n_gnt++;
        end
        if (redirect_valid) begin
            if (imem_req && !imem_gnt && !stale) begin
                stale = 1; stale_addr = exp_fetch;
            end
            exp_fetch = redirect_pc & ~32'd3;
            exp_dlv   = redirect_pc & ~32'd3;
            arm_first = 1;
        end
        prev_wait = imem_req && !imem_gnt;
        prev_addr = imem_addr;
    endtask

    initial begin
        int g0;
        rstn = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;
        spur_en = 0; frc_vld = 0; first_dlv = '1;
        set_knobs(100, 100, 100, 0);

        // Full-rate sequential fetch after the boot cycle.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            step();
            if (k == 0) chk("boot_no_req", {31'd0, imem_req}, 32'd0);
            else begin
                chk("t1_req",  {31'd0, imem_req}, 32'd1);
                chk("t1_addr", imem_addr, RESET_VEC + 32'(4 * (k - 1)));
            end
            if (k >= 3) chk("t1_no_bubble", {31'd0, if_valid}, 32'd1);
        end

        // Decode stall: fetch stops at MAX_OUT, buffered order preserved on release.
        do_reset();
        set_knobs(100, 100, 0, 0);
        g0 = n_gnt;
        for (int k = 0; k < 11; k++) step();
        chk("t2_grants", 32'(n_gnt - g0), 32'(MAX_OUT));
        chk("t2_req_off", {31'd0, imem_req}, 32'd0);
        chk("t2_head", if_pc, RESET_VEC);
        rdy_pct = 100;
        for (int k = 0; k < 6; k++) step();

        // Redirect with two in flight; misaligned target.
        do_reset();
        set_knobs(100, 0, 100, 0);
        frc(32'h10); step();
        step(); step(); step();
        chk("t3_stall", {31'd0, imem_req}, 32'd0);
        frc(32'h203); step();
        step();
        chk("t3_target", imem_addr, 32'h200);
        rv_pct = 100;
        for (int k = 0; k < 8; k++) step();
        chk("t3_first", first_dlv, 32'h200);

        // Redirect while a request is held without grant.
        do_reset();
        set_knobs(0, 0, 100, 0);
        frc(32'h40); step();
        step();
        chk("t4_req",  {31'd0, imem_req}, 32'd1);
        chk("t4_addr", imem_addr, 32'h40);
        frc(32'h80); step();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_hold", imem_addr, 32'h40);
        end
        gnt_pct = 100; rv_pct = 100;
        step();
        step();
        chk("t4_next", imem_addr, 32'h80);
        for (int k = 0; k < 6; k++) step();
        chk("t4_first", first_dlv, 32'h80);

        // Back-to-back redirects: the later target wins.
        do_reset();
        set_knobs(100, 0, 100, 0);
        step(); step(); step();
        frc(32'h100); step();
        frc(32'h300); step();
        rv_pct = 100;
        for (int k = 0; k < 10; k++) step();
        chk("t5_first", first_dlv, 32'h300);

        // Reset mid-stream with a request pending and an instruction buffered.
        do_reset();
        set_knobs(100, 100, 0, 0);
        step(); step();
        gnt_pct = 0;
        step(); step();
        chk("t6_pre_vld", {31'd0, if_valid}, 32'd1);
        chk("t6_pre_req", {31'd0, imem_req}, 32'd1);
        do_reset();
        set_knobs(100, 100, 100, 0);
        step(); step();
        chk("t6_restart_req",  {31'd0, imem_req}, 32'd1);
        chk("t6_restart_addr", imem_addr, RESET_VEC);
        for (int k = 0; k < 4; k++) step();

        // Randomized traffic, with stray responses and one reset in the middle.
        spur_en = 1;
        for (int s = 0; s < 40; s++) begin
            if (s == 20) do_reset();
            set_knobs($urandom_range(30, 100), $urandom_range(30, 100),
                      $urandom_range(20, 100), $urandom_range(0, 10));
            for (int k = 0; k < 80; k++) step();
        end
        chk("liveness", {31'd0, (n_dlv > 200)}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
